// File: rtl/prbs16_checker.sv
// Serial PRBS-16 checker: self-synchronises to the generator stream, then
// flywheels on its own prediction, counting and windowing bit errors.
module prbs16_checker #(
    parameter logic [15:0] TAPS     = 16'hB400,
    parameter int          SYNC_LEN = 32,
    parameter int          LOSS_WIN = 64,
    parameter int          LOSS_THR = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [1:0]  state
);

    localparam int RUN_W  = $clog2(SYNC_LEN + 1);
    localparam int WIN_W  = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    localparam int WERR_W = $clog2(LOSS_THR + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         s_q, s_d;
    logic [4:0]          fill_q, fill_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]   win_err_q, win_err_d;
    logic [15:0]         err_count_q, err_count_d;
    logic                err_pulse_q, err_pulse_d;
    logic                locked_q, locked_d;
    logic                predicted;
    logic                mismatch;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        run_d       = run_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        predicted   = ^(s_q & TAPS);
        mismatch    = bit_in ^ predicted;

        if (clear) begin
            state_d     = HUNT;
            fill_d      = '0;
            run_d       = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
            err_count_d = '0;
        end else if (bit_valid) begin
            case (state_q)
                HUNT: begin
                    s_d    = {s_q[14:0], bit_in};
                    fill_d = fill_q + 5'd1;
                    if (fill_q == 5'd15) begin
                        state_d = VERIFY;
                        run_d   = '0;
                    end
                end
                VERIFY: begin
                    s_d = {s_q[14:0], bit_in};
                    if (mismatch) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                        if (run_q == RUN_W'(SYNC_LEN - 1)) begin
                            state_d   = LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: the register only ever takes its own prediction,
                    // so line errors cannot poison later predictions.
                    s_d = {s_q[14:0], predicted};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                    end
                    if (mismatch && (win_err_q == WERR_W'(LOSS_THR - 1))) begin
                        state_d   = HUNT;
                        fill_d    = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == WIN_W'(LOSS_WIN - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        if (mismatch) begin
                            win_err_d = win_err_q + WERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= HUNT;
            s_q         <= '0;
            fill_q      <= '0;
            run_q       <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker: default instance for lock/loss/window
// behaviour, a high-threshold instance to drive err_count into saturation.
`timescale 1ns/1ps
module tb_prbs16_checker;

    localparam logic [15:0] TAPS = 16'hB400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        bit_in;
    logic        bit_valid;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;
    logic        sat_locked, sat_err_pulse;
    logic [15:0] sat_err_count;
    logic [1:0]  sat_state;

    typedef struct {
        logic exp_pulse;
        logic on_sat;
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] gen;
    logic        use_sat;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    prbs16_checker dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state(state)
    );

    // Threshold above the window length: it can never lose lock, so every
    // error bit lands in err_count.
    prbs16_checker #(.LOSS_THR(65)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .locked(sat_locked), .err_pulse(sat_err_pulse), .err_count(sat_err_count),
        .state(sat_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the expected err_pulse is queued at drive time
    // and retired once the edge has produced the DUT's answer.
    task automatic drive(input logic valid, input logic inv, input logic exp_pulse);
        logic b;
        sb_t  item;
        if (valid) begin
            b      = ^(gen & TAPS);
            gen    = {gen[14:0], b};
            bit_in = b ^ inv;
        end else begin
            bit_in = 1'($urandom_range(0, 1));
        end
        bit_valid = valid;
        sb_q.push_back('{exp_pulse: exp_pulse, on_sat: use_sat});
        @(posedge clk);
        #1;
        item = sb_q.pop_front();
        if (item.on_sat) check("sat_err_pulse", 32'(sat_err_pulse), 32'(item.exp_pulse));
        else             check("err_pulse", 32'(err_pulse), 32'(item.exp_pulse));
        bit_valid = 1'b0;
    endtask

    task automatic clean(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic gapped(input logic inv);
        repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, inv, 1'b0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        check("clear_state", 32'(state), 32'd0);
        check("clear_count", 32'(err_count), 32'd0);
    endtask

    task automatic relock(input string tag);
        clean(15);
        check({tag, "_hunt15"}, 32'(state), 32'd0);
        clean(1);
        check({tag, "_verify16"}, 32'(state), 32'd1);
        clean(31);
        check({tag, "_unlocked47"}, 32'(locked), 32'd0);
        clean(1);
        check({tag, "_locked48"}, 32'(locked), 32'd1);
        check({tag, "_state48"}, 32'(state), 32'd2);
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        use_sat   = 1'b0;
        gen       = 16'hACE1;
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pulse", 32'(err_pulse), 32'd0);
        check("rst_count", 32'(err_count), 32'd0);
        check("rst_sat_count", 32'(sat_err_count), 32'd0);
        rst_n = 1'b1;

        // Clean acquisition from reset, then a long error-free run.
        relock("acq");
        clean(952);
        check("clean_count", 32'(err_count), 32'd0);
        check("clean_locked", 32'(locked), 32'd1);

        // Single error: one pulse, count 1, flywheel holds for 100 bits.
        drive(1'b1, 1'b1, 1'b1);
        check("single_count", 32'(err_count), 32'd1);
        check("single_locked", 32'(locked), 32'd1);
        clean(100);
        check("single_hold_count", 32'(err_count), 32'd1);
        check("single_hold_locked", 32'(locked), 32'd1);

        // Loss of lock: eight errors inside one window.
        do_clear();
        relock("loss_pre");
        repeat (7) begin
            drive(1'b1, 1'b1, 1'b1);
            drive(1'b1, 1'b0, 1'b0);
        end
        check("loss7_locked", 32'(locked), 32'd1);
        check("loss7_count", 32'(err_count), 32'd7);
        drive(1'b1, 1'b1, 1'b1);
        check("loss8_locked", 32'(locked), 32'd0);
        check("loss8_state", 32'(state), 32'd0);
        check("loss8_count", 32'(err_count), 32'd8);
        relock("loss_relock");
        check("loss_relock_count", 32'(err_count), 32'd8);

        // Window boundary: seven errors ending on the last bit of window N,
        // one on the first bit of window N+1.
        do_clear();
        relock("win_pre");
        clean(57);
        repeat (7) drive(1'b1, 1'b1, 1'b1);
        check("win_n_locked", 32'(locked), 32'd1);
        check("win_n_count", 32'(err_count), 32'd7);
        drive(1'b1, 1'b1, 1'b1);
        check("win_n1_locked", 32'(locked), 32'd1);
        check("win_n1_count", 32'(err_count), 32'd8);
        clean(20);
        check("win_hold_locked", 32'(locked), 32'd1);
        check("win_hold_count", 32'(err_count), 32'd8);

        // VERIFY failure on bit 20 with random valid gaps.
        do_clear();
        repeat (16) gapped(1'b0);
        check("gap_verify", 32'(state), 32'd1);
        repeat (3) gapped(1'b0);
        gapped(1'b1);
        check("gap_fail_state", 32'(state), 32'd0);
        check("gap_fail_locked", 32'(locked), 32'd0);
        repeat (15) gapped(1'b0);
        check("gap_hunt15", 32'(state), 32'd0);
        gapped(1'b0);
        check("gap_verify16", 32'(state), 32'd1);
        repeat (31) gapped(1'b0);
        check("gap_unlocked47", 32'(locked), 32'd0);
        gapped(1'b0);
        check("gap_locked48", 32'(locked), 32'd1);

        // Asynchronous reset mid-lock, asserted between clock edges.
        clean(10);
        check("prereset_locked", 32'(locked), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_locked", 32'(locked), 32'd0);
        check("async_state", 32'(state), 32'd0);
        check("async_sat_locked", 32'(sat_locked), 32'd0);
        #2;
        rst_n = 1'b1;

        // Saturation on the high-threshold instance.
        use_sat = 1'b1;
        clean(47);
        check("sat_unlocked47", 32'(sat_locked), 32'd0);
        clean(1);
        check("sat_locked48", 32'(sat_locked), 32'd1);
        repeat (65534) drive(1'b1, 1'b1, 1'b1);
        check("sat_fffe", 32'(sat_err_count), 32'h0000_FFFE);
        check("sat_fffe_locked", 32'(sat_locked), 32'd1);
        drive(1'b1, 1'b1, 1'b1);
        check("sat_ffff", 32'(sat_err_count), 32'h0000_FFFF);
        repeat (20) drive(1'b1, 1'b1, 1'b1);
        check("sat_hold", 32'(sat_err_count), 32'h0000_FFFF);
        check("sat_hold_state", 32'(sat_state), 32'd2);

        // clear together with an error bit wins: no pulse, count zeroed.
        clear = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        clear = 1'b0;
        check("sat_clear_count", 32'(sat_err_count), 32'd0);
        check("sat_clear_state", 32'(sat_state), 32'd0);
        check("sat_clear_locked", 32'(sat_locked), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs16_checker.md
# prbs16_checker

Serial PRBS-16 checker that sits directly downstream of the LFSR pattern generator. It consumes the generator's one-bit-per-strobe output stream, self-synchronises to it, and then counts bit errors against a locally predicted sequence. It declares loss of lock when errors exceed a windowed threshold, and reports lock, error strobes and a saturating error count for readback.

## Interface
Parameters:
- TAPS, 16'hB400: Fibonacci tap mask for x^16+x^14+x^13+x^11+1 (register bits 15, 13, 12, 10).
- SYNC_LEN, 32: consecutive correct predictions required in VERIFY before LOCKED.
- LOSS_WIN, 64: length of the loss-detection window, in valid bits.
- LOSS_THR, 8: errors within one window that force re-hunt.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; zeroes err_count and returns to HUNT.
- bit_in  in  1  received PRBS bit; sampled only when bit_valid=1.
- bit_valid  in  1  qualifies bit_in for one cycle.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle strobe per mismatched bit while LOCKED.
- err_count  out  16  saturating error total.
- state  out  2  encoding: 0=HUNT, 1=VERIFY, 2=LOCKED.

## Operation
- Shift register s[15:0]. On each accepted bit: s <= {s[14:0], b}.
- Predicted bit: p = ^(s & TAPS), computed from s before the shift.
- HUNT:
  - b = bit_in.
  - fill counter (5 bits) increments per valid bit.
  - When fill reaches 16, go to VERIFY with run counter = 0.
- VERIFY:
  - b = bit_in.
  - bit_in == p: run increments; when run reaches SYNC_LEN, go to LOCKED and reset the window counters.
  - Mismatch: go to HUNT with fill = 0. The register keeps the received bits; the next fill restarts from 0.
- LOCKED (flywheel):
  - b = p. The local predictor is never corrupted by line errors.
  - Mismatch: err_pulse asserted; err_count increments, saturating at 16'hFFFF; win_err increments, saturating at LOSS_THR.
  - win_cnt counts valid bits. When it reaches LOSS_WIN-1 on an accepted bit, both win_cnt and win_err reset to 0.
  - If win_err would reach LOSS_THR on this bit, go to HUNT with fill = 0. err_count keeps its value and is cleared only by clear or reset.
- Cycles with bit_valid=0: nothing changes, and err_pulse=0.
- clear has priority over bit processing in the same cycle. It sets err_count=0, state=HUNT, fill=0, run=0 and window counters=0. s is left unchanged.
- Reset values: s=16'h0000, state=HUNT, all counters 0, locked=0, err_pulse=0, err_count=0.
- An all-zero s in VERIFY predicts 0 forever. Reaching LOCKED on an all-zero stream is acceptable; the generator never emits it.

## Timing
- All outputs are registered.
- err_pulse rises in the cycle after the edge that samples the erroneous bit and lasts exactly one cycle.
- locked rises on the edge that accepts the SYNC_LEN-th correct VERIFY bit. Minimum acquisition is 16+SYNC_LEN = 48 valid bits from reset.
- locked falls on the edge that accepts the LOSS_THR-th windowed error.
- bit_valid may be asserted every cycle, giving full throughput, or sparsely; behaviour depends only on the valid-bit sequence.
- rst_n assertion mid-stream forces reset values immediately, independent of clk.

## Test plan
- Clean lock: reset, then feed generator seed 16'hACE1, one bit per cycle. Required: state=VERIFY after 16 bits, locked=1 after bit 48, err_count=0 after 1000 bits.
- Single error: after lock, invert 1 bit. Required: exactly one err_pulse, err_count=1, locked stays 1, and the next 100 bits produce no further pulses (flywheel holds).
- Loss of lock: after lock, invert 8 bits within 64. Required: locked falls on the 8th error, state=HUNT, err_count=8, and re-lock occurs 48 valid bits after the errors stop.
- Window boundary: invert 7 bits in window N, then 1 bit early in window N+1. Required: locked stays 1 and err_count=8.
- VERIFY failure and gaps: corrupt bit 20 during acquisition with random bit_valid gaps. Required: return to HUNT with fill=0, then lock 48 valid bits later regardless of gaps.
- Saturation, clear and reset: force err_count to 16'hFFFF with sustained errors (re-locking as needed). Required: it holds at FFFF. clear asserted together with an error bit gives err_count=0, state=HUNT and no err_pulse. Asserting rst_n low mid-lock drops locked immediately.
